fpu_sequencer: RTL and testbench
================================

Name: fpu_sequencer

Overview:
- Command-level controller in front of the `fpu` datapath.
- Accepts one operation plus two packed operands over a valid/ready command port and latches the operands stable for the whole operation.
- Issues a single-cycle operation strobe to the FPU, tracks completion via the FPU `idle` output, or via a fixed wait for sqrt (the FPU never drops `idle` for sqrt).
- Returns result plus flags over a valid/ready response port. Also owns FPU reset and recovery from a hung operation (watchdog).

Parameters:
- TIMEOUT, 63: watchdog cycles allowed in any wait state before abort.
- SQRT_WAIT, 20: cycles waited after the sqrt strobe before capturing the result.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  3  0=add 1=sub 2=mul 3=div 4=sqrt, 5-7 illegal
- cmd_a  in  23  operand 1 {s,e[6:0],m[14:0]}
- cmd_b  in  23  operand 2, same packing (ignored for sqrt)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  23  result {s,e,m}
- rsp_flags  out  5  {illegal,timeout,underflow,overflow,zero}
- fpu_reset  out  1  active-high reset to FPU
- fpu_add, fpu_sub, fpu_mul, fpu_div, fpu_sqrt  out  1 each  op strobes
- fpu_reg1_s/e/m, fpu_reg2_s/e/m  out  1/7/15  operand fields
- fpu_res_s/e/m  in  1/7/15  FPU result
- fpu_zero, fpu_ovf, fpu_unf, fpu_idle  in  1 each  FPU flags / idle

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=INIT; outputs cleared: all strobes 0, cmd_ready 0, rsp_valid 0, rsp_data 0, rsp_flags 0, operand regs 0, watchdog 0.
  - fpu_reset=1 while rst_n=0 and for exactly one cycle after release.
  - A reset mid-operation discards the operation; no response is produced.
- States and transitions:
  - INIT:
    - fpu_reset deasserted.
    - Wait for fpu_idle==1, which is not reset-defined in the FPU (expected 1-2 cycles after FPU reset release), then go to IDLE.
    - Watchdog runs; on expiry, re-pulse fpu_reset and restart INIT.
  - IDLE:
    - cmd_ready=1.
    - On cmd_valid&cmd_ready, latch op/cmd_a/cmd_b into the operand registers. The operand registers drive fpu_reg* continuously until the next accept.
    - Legal op -> ISSUE.
    - Illegal op -> RESP with flags=10000, data=0, no strobe.
  - ISSUE:
    - Exactly one strobe high for exactly one cycle; a strobe longer than one cycle would restart the FPU.
    - Watchdog cleared.
    - sqrt -> WAIT_FIXED; others -> WAIT_BUSY.
  - WAIT_BUSY: wait for fpu_idle==0 (expected 2nd cycle after the strobe), then -> WAIT_DONE.
  - WAIT_DONE: wait for fpu_idle==1, then capture fpu_res_* and flags into rsp_data/rsp_flags[2:0], then -> RESP.
  - WAIT_FIXED: count SQRT_WAIT cycles, then capture as in WAIT_DONE, then -> RESP.
  - Watchdog in WAIT_BUSY/WAIT_DONE: reaching TIMEOUT -> capture data 0, flags=01000, pulse fpu_reset one cycle, then -> RESP. The next IDLE is entered only via INIT.
  - RESP:
    - rsp_valid=1; rsp_data/rsp_flags held stable until rsp_valid&rsp_ready.
    - After the handshake: rsp_valid=0 next cycle; go to IDLE, or INIT after a timeout.
    - cmd_ready stays 0 in RESP, so no same-cycle accept. Minimum command-to-command spacing is one idle cycle.
- Exactly one command is in flight; commands are never queued.
- rsp_flags[4:3] are never both 1.
- cmd_* inputs are ignored outside IDLE.

Decomposition:
- Shared package holds:
  - op encodings (OP_ADD..OP_SQRT)
  - field offsets for the 23-bit packing (S_BIT=22, E_MSB=21, E_LSB=15, M_MSB=14)
  - flag bit indices
  - state enum constants
- One natural sub-module: `seq_watchdog`. It is a loadable down-counter with clear, enable and expire outputs, shared by INIT, WAIT_* and WAIT_FIXED (the last loaded with SQRT_WAIT).
- The FSM and the operand/result registers stay in the top.

Test Plan:
- Add with the real fpu instance:
  - Stimulus: op=0, a=b={1,7'd1,15'h4000} (2.0).
  - Required: one fpu_add pulse; rsp_data={1,7'd2,15'h4000}; flags=00000; fpu_reg* stable from strobe to response.
- Sqrt:
  - Stimulus: op=4, a={1,7'd2,15'h4000}.
  - Required: fpu_idle never drops; response exactly SQRT_WAIT cycles after the strobe, plus capture latency; rsp_data e field = 7'd1, s=1.
- Illegal op=6:
  - Required: no strobe; rsp_valid in the cycle after accept; flags=10000.
- Back-pressure:
  - Stimulus: hold rsp_ready=0 for 10 cycles after a mul of 2.0×2.0.
  - Required: rsp_valid and data stay constant; cmd_ready=0 throughout; cmd_ready returns 1 one cycle after the handshake.
- Timeout, using an fpu stub whose idle stays 1 for add:
  - Required: after TIMEOUT cycles in WAIT_BUSY, flags=01000; one-cycle fpu_reset pulse; the controller passes through INIT before cmd_ready=1.
- Reset mid-operation:
  - Stimulus: drop rst_n during WAIT_DONE of a div.
  - Required: rsp_valid=0; all strobes 0; fpu_reset=1; after release, INIT then IDLE with no stale response.

Source files
------------

// File: rtl/fpu_sequencer_pkg.sv
// Shared encodings for the FPU command sequencer: op codes, word packing,
// response flag positions and controller states.
package fpu_sequencer_pkg;

    localparam int W_WORD  = 23;
    localparam int W_FLAGS = 5;

    // {s, e[6:0], m[14:0]}
    localparam int S_BIT = 22;
    localparam int E_MSB = 21;
    localparam int E_LSB = 15;
    localparam int M_MSB = 14;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_SQRT = 3'd4;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_UNF  = 2;
    localparam int FLAG_TMO  = 3;
    localparam int FLAG_ILL  = 4;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_WAIT_FIXED,
        ST_RESP
    } state_t;

    typedef logic [W_WORD-1:0] word_t;

    typedef struct packed {
        logic [2:0] op;
        word_t      a;
        word_t      b;
    } cmd_t;

    typedef struct packed {
        word_t              data;
        logic [W_FLAGS-1:0] flags;
    } rsp_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_SQRT;
    endfunction

endpackage

// File: rtl/fpu_sequencer_watchdog.sv
// Loadable down-counter shared by the sequencer's wait states; expire flags
// the terminal count so the owner decides what to do with it.
module seq_watchdog #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && count != '0)
            count <= count - 1'b1;
    end

    // A load of N expires in the Nth enabled cycle after the load.
    assign expire = (count <= W'(1));

endmodule

// File: rtl/fpu_sequencer.sv
// Command-level controller for the fpu datapath: one operation in flight,
// single-cycle strobes, idle/fixed-wait completion, watchdog recovery.
module fpu_sequencer
    import fpu_sequencer_pkg::*;
#(
    parameter int TIMEOUT   = 63,
    parameter int SQRT_WAIT = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [22:0] cmd_a,
    input  logic [22:0] cmd_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [22:0] rsp_data,
    output logic [4:0]  rsp_flags,
    output logic        fpu_reset,
    output logic        fpu_add,
    output logic        fpu_sub,
    output logic        fpu_mul,
    output logic        fpu_div,
    output logic        fpu_sqrt,
    output logic        fpu_reg1_s,
    output logic [6:0]  fpu_reg1_e,
    output logic [14:0] fpu_reg1_m,
    output logic        fpu_reg2_s,
    output logic [6:0]  fpu_reg2_e,
    output logic [14:0] fpu_reg2_m,
    input  logic        fpu_res_s,
    input  logic [6:0]  fpu_res_e,
    input  logic [14:0] fpu_res_m,
    input  logic        fpu_zero,
    input  logic        fpu_ovf,
    input  logic        fpu_unf,
    input  logic        fpu_idle
);

    localparam int WD_MAX = (TIMEOUT > SQRT_WAIT) ? TIMEOUT : SQRT_WAIT;
    localparam int WD_W   = $clog2(WD_MAX + 1);
    localparam logic [WD_W-1:0] WD_TIMEOUT = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_SQRT    = WD_W'(SQRT_WAIT);

    state_t          state, state_nx;
    cmd_t            cmd_q;
    rsp_t            rsp_q;
    logic            fpu_reset_q, fpu_reset_nx;
    logic            cap_res, cap_tmo;
    logic            wd_clear, wd_load, wd_en, wd_expire;
    logic [WD_W-1:0] wd_val;
    logic            accept;

    assign accept = cmd_valid && cmd_ready;

    seq_watchdog #(.W(WD_W)) u_wd (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wd_clear),
        .load     (wd_load),
        .load_val (wd_val),
        .en       (wd_en),
        .expire   (wd_expire)
    );

    // fpu_reset is registered so it stays high for the cycle after rst_n release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_INIT;
            fpu_reset_q <= 1'b1;
        end else begin
            state       <= state_nx;
            fpu_reset_q <= fpu_reset_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        fpu_reset_nx = 1'b0;
        cap_res      = 1'b0;
        cap_tmo      = 1'b0;
        wd_clear     = 1'b0;
        wd_load      = 1'b0;
        wd_en        = 1'b0;
        wd_val       = WD_TIMEOUT;
        case (state)
            ST_INIT: begin
                // Hold the budget while the FPU is still in reset; idle is undefined then.
                if (fpu_reset_q) begin
                    wd_load = 1'b1;
                end else begin
                    wd_en = 1'b1;
                    if (fpu_idle)
                        state_nx = ST_IDLE;
                    else if (wd_expire)
                        fpu_reset_nx = 1'b1;
                end
            end
            ST_IDLE: begin
                wd_clear = 1'b1;
                if (accept)
                    state_nx = op_legal(cmd_op) ? ST_ISSUE : ST_RESP;
            end
            ST_ISSUE: begin
                wd_load = 1'b1;
                if (cmd_q.op == OP_SQRT) begin
                    wd_val   = WD_SQRT;
                    state_nx = ST_WAIT_FIXED;
                end else begin
                    state_nx = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                wd_en = 1'b1;
                if (!fpu_idle) begin
                    state_nx = ST_WAIT_DONE;
                end else if (wd_expire) begin
                    cap_tmo      = 1'b1;
                    fpu_reset_nx = 1'b1;
                    state_nx     = ST_RESP;
                end
            end
            ST_WAIT_DONE: begin
                wd_en = 1'b1;
                if (fpu_idle) begin
                    cap_res  = 1'b1;
                    state_nx = ST_RESP;
                end else if (wd_expire) begin
                    cap_tmo      = 1'b1;
                    fpu_reset_nx = 1'b1;
                    state_nx     = ST_RESP;
                end
            end
            ST_WAIT_FIXED: begin
                wd_en = 1'b1;
                if (wd_expire) begin
                    cap_res  = 1'b1;
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    if (rsp_q.flags[FLAG_TMO]) begin
                        wd_load  = 1'b1;
                        state_nx = ST_INIT;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_INIT;
        endcase
    end

    always_comb begin
        cmd_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        fpu_add   = 1'b0;
        fpu_sub   = 1'b0;
        fpu_mul   = 1'b0;
        fpu_div   = 1'b0;
        fpu_sqrt  = 1'b0;
        if (state == ST_ISSUE) begin
            case (cmd_q.op)
                OP_ADD:  fpu_add  = 1'b1;
                OP_SUB:  fpu_sub  = 1'b1;
                OP_MUL:  fpu_mul  = 1'b1;
                OP_DIV:  fpu_div  = 1'b1;
                OP_SQRT: fpu_sqrt = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_q <= '0;
            rsp_q <= '0;
        end else begin
            if (accept) begin
                cmd_q <= '{op: cmd_op, a: cmd_a, b: cmd_b};
                if (!op_legal(cmd_op)) begin
                    rsp_q.data            <= '0;
                    rsp_q.flags           <= '0;
                    rsp_q.flags[FLAG_ILL] <= 1'b1;
                end
            end
            if (cap_res) begin
                rsp_q.data             <= {fpu_res_s, fpu_res_e, fpu_res_m};
                rsp_q.flags            <= '0;
                rsp_q.flags[FLAG_ZERO] <= fpu_zero;
                rsp_q.flags[FLAG_OVF]  <= fpu_ovf;
                rsp_q.flags[FLAG_UNF]  <= fpu_unf;
            end
            if (cap_tmo) begin
                rsp_q.data            <= '0;
                rsp_q.flags           <= '0;
                rsp_q.flags[FLAG_TMO] <= 1'b1;
            end
        end
    end

    assign rsp_data   = rsp_q.data;
    assign rsp_flags  = rsp_q.flags;
    assign fpu_reset  = fpu_reset_q;
    assign fpu_reg1_s = cmd_q.a[S_BIT];
    assign fpu_reg1_e = cmd_q.a[E_MSB:E_LSB];
    assign fpu_reg1_m = cmd_q.a[M_MSB:0];
    assign fpu_reg2_s = cmd_q.b[S_BIT];
    assign fpu_reg2_e = cmd_q.b[E_MSB:E_LSB];
    assign fpu_reg2_m = cmd_q.b[M_MSB:0];

endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer with a behavioural FPU stub whose results
// are a toy function of the latched operands (exact for the vectors used).
module tb_fpu_sequencer;
    import fpu_sequencer_pkg::*;

    localparam int TIMEOUT   = 63;
    localparam int SQRT_WAIT = 20;
    localparam logic [22:0] TWO  = {1'b1, 7'd1, 15'h4000};
    localparam logic [22:0] FOUR = {1'b1, 7'd2, 15'h4000};
    localparam logic [22:0] EIGHT = {1'b1, 7'd3, 15'h4000};
    localparam logic [25:0] JUNK = 26'h2d5a5a5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [2:0]  cmd_op;
    logic [22:0] cmd_a, cmd_b, rsp_data;
    logic [4:0]  rsp_flags;
    logic        fpu_reset, fpu_add, fpu_sub, fpu_mul, fpu_div, fpu_sqrt;
    logic        fpu_reg1_s, fpu_reg2_s, fpu_res_s;
    logic [6:0]  fpu_reg1_e, fpu_reg2_e, fpu_res_e;
    logic [14:0] fpu_reg1_m, fpu_reg2_m, fpu_res_m;
    logic        fpu_zero, fpu_ovf, fpu_unf, fpu_idle;

    fpu_sequencer #(.TIMEOUT(TIMEOUT), .SQRT_WAIT(SQRT_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .fpu_reset(fpu_reset),
        .fpu_add(fpu_add), .fpu_sub(fpu_sub), .fpu_mul(fpu_mul),
        .fpu_div(fpu_div), .fpu_sqrt(fpu_sqrt),
        .fpu_reg1_s(fpu_reg1_s), .fpu_reg1_e(fpu_reg1_e), .fpu_reg1_m(fpu_reg1_m),
        .fpu_reg2_s(fpu_reg2_s), .fpu_reg2_e(fpu_reg2_e), .fpu_reg2_m(fpu_reg2_m),
        .fpu_res_s(fpu_res_s), .fpu_res_e(fpu_res_e), .fpu_res_m(fpu_res_m),
        .fpu_zero(fpu_zero), .fpu_ovf(fpu_ovf), .fpu_unf(fpu_unf),
        .fpu_idle(fpu_idle)
    );

    logic [22:0] a_w, b_w;
    assign a_w = {fpu_reg1_s, fpu_reg1_e, fpu_reg1_m};
    assign b_w = {fpu_reg2_s, fpu_reg2_e, fpu_reg2_m};

    function automatic logic [4:0] strb();
        return {fpu_add, fpu_sub, fpu_mul, fpu_div, fpu_sqrt};
    endfunction

    // {unf, ovf, zero, data}
    function automatic logic [25:0] toy(input logic [2:0] op, input logic [22:0] a, input logic [22:0] b);
        case (op)
            OP_ADD:  return {3'b000, a[22], a[21:15] + 7'd1, a[14:0]};
            OP_SUB:  return (a == b) ? {3'b001, 23'd0} : {3'b000, a};
            OP_MUL:  return {3'b000, a[22], a[21:15] + b[21:15], a[14:0]};
            OP_DIV:  return {3'b000, a[22], a[21:15] - b[21:15], a[14:0]};
            default: return {3'b000, a[22], a[21:15] >> 1, a[14:0]};
        endcase
    endfunction

    // FPU stub: idle rises 2 cycles after reset release; idle drops on the 2nd
    // cycle after a strobe, busy 6 cycles; sqrt keeps idle high.
    logic        stub_hang = 1'b0;
    logic [25:0] res_bus, res_nx;
    logic        pend;
    int          rcnt = 0, busy = 0, sq = 0;
    assign {fpu_unf, fpu_ovf, fpu_zero, fpu_res_s, fpu_res_e, fpu_res_m} = res_bus;

    always @(posedge clk) begin
        if (fpu_reset) begin
            fpu_idle <= 1'b0; rcnt <= 2; pend <= 1'b0; busy <= 0; sq <= 0; res_bus <= '0;
        end else if (rcnt != 0) begin
            rcnt <= rcnt - 1;
            if (rcnt == 1) fpu_idle <= 1'b1;
        end else begin
            if ((fpu_add | fpu_sub | fpu_mul | fpu_div) && !stub_hang) begin
                pend    <= 1'b1;
                res_bus <= JUNK;
                res_nx  <= toy(fpu_add ? OP_ADD : fpu_sub ? OP_SUB : fpu_mul ? OP_MUL : OP_DIV, a_w, b_w);
            end
            if (pend) begin
                pend <= 1'b0; fpu_idle <= 1'b0; busy <= 6;
            end else if (busy != 0) begin
                busy <= busy - 1;
                if (busy == 1) begin fpu_idle <= 1'b1; res_bus <= res_nx; end
            end
            if (fpu_sqrt) begin
                sq <= 12; res_bus <= JUNK; res_nx <= toy(OP_SQRT, a_w, b_w);
            end else if (sq != 0) begin
                sq <= sq - 1;
                if (sq == 1) res_bus <= res_nx;
            end
        end
    end

    int strobe_cnt = 0, strobe_err = 0, rst_cnt = 0;
    logic [4:0] strb_prev = '0;
    always @(posedge clk) begin
        strobe_cnt <= strobe_cnt + ((strb() != 5'd0) ? 1 : 0);
        if ($countones(strb()) > 1 || (strb() & strb_prev) != 5'd0) strobe_err <= strobe_err + 1;
        strb_prev <= strb();
        rst_cnt <= rst_cnt + (fpu_reset ? 1 : 0);
    end

    int checks = 0, errors = 0;
    int reg_bad, idle_drop, stale, bp_bad, n, s0, r0;
    logic [45:0] exp_regs;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [22:0] a, input logic [22:0] b);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        exp_regs = {a, b}; reg_bad = 0; idle_drop = 0;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int cnt);
        cnt = 0;
        while (!rsp_valid && cnt < budget) begin
            step(); cnt++;
            if ({a_w, b_w} !== exp_regs) reg_bad++;
            if (!fpu_idle) idle_drop++;
        end
        chk("rsp_seen", rsp_valid, 1);
    endtask

    task automatic wait_ready(input int budget, output int cnt);
        cnt = 0; stale = 0;
        while (!cmd_ready && cnt < budget) begin
            step(); cnt++;
            if (rsp_valid) stale++;
        end
        chk("ready_seen", cmd_ready, 1);
    endtask

    task automatic handshake(input logic exp_ready);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("hs_rsp_valid", rsp_valid, 0);
        chk("hs_cmd_ready", cmd_ready, exp_ready);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        repeat (3) step();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_data_flags", {rsp_data, rsp_flags}, 0);
        chk("rst_fpu_reset", fpu_reset, 1);
        chk("rst_strobes", strb(), 0);
        chk("rst_regs", {a_w, b_w}, 0);
        rst_n = 1'b1;
        step();
        chk("rst_release_pulse", fpu_reset, 0);
        wait_ready(200, n);
        chk("init_cycles", n, 3);

        // add 2.0 + 2.0
        s0 = strobe_cnt;
        send(OP_ADD, TWO, TWO);
        chk("add_strobe", strb(), 5'b10000);
        chk("add_regs", {a_w, b_w}, {TWO, TWO});
        wait_rsp(100, n);
        chk("add_data", rsp_data, FOUR);
        chk("add_flags", rsp_flags, 5'b00000);
        chk("add_reg_stable", reg_bad, 0);
        chk("add_one_strobe", strobe_cnt - s0, 1);
        handshake(1'b1);

        // sub with equal operands gives zero
        send(OP_SUB, TWO, TWO);
        wait_rsp(100, n);
        chk("sub_data", rsp_data, 0);
        chk("sub_flags", rsp_flags, 5'b00001);
        handshake(1'b1);

        // sqrt 4.0: fixed wait
        send(OP_SQRT, FOUR, 23'd0);
        chk("sqrt_strobe", strb(), 5'b00001);
        wait_rsp(100, n);
        chk("sqrt_latency", n, SQRT_WAIT + 1);
        chk("sqrt_data", rsp_data, TWO);
        chk("sqrt_idle_high", idle_drop, 0);
        handshake(1'b1);

        // illegal op
        s0 = strobe_cnt;
        send(3'd6, TWO, TWO);
        chk("ill_rsp_valid", rsp_valid, 1);
        chk("ill_flags", rsp_flags, 5'b10000);
        chk("ill_data", rsp_data, 0);
        handshake(1'b1);
        chk("ill_no_strobe", strobe_cnt - s0, 0);

        // back-pressure on a mul, with a command waving at the port meanwhile
        send(OP_MUL, TWO, TWO);
        wait_rsp(100, n);
        chk("mul_data", rsp_data, FOUR);
        s0 = strobe_cnt; bp_bad = 0;
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = EIGHT; cmd_b = EIGHT;
        repeat (10) begin
            step();
            if (!rsp_valid || rsp_data !== FOUR || rsp_flags !== 5'b0 || cmd_ready) bp_bad++;
        end
        cmd_valid = 1'b0;
        chk("bp_hold", bp_bad, 0);
        handshake(1'b1);
        chk("bp_no_strobe", strobe_cnt - s0, 0);

        // timeout: stub never leaves idle
        stub_hang = 1'b1;
        r0 = rst_cnt;
        send(OP_ADD, TWO, TWO);
        wait_rsp(200, n);
        chk("tmo_latency", n, TIMEOUT + 1);
        chk("tmo_flags", rsp_flags, 5'b01000);
        chk("tmo_data", rsp_data, 0);
        chk("tmo_fpu_reset", fpu_reset, 1);
        stub_hang = 1'b0;
        step();
        chk("tmo_reset_drop", fpu_reset, 0);
        chk("tmo_rsp_held", rsp_valid, 1);
        handshake(1'b0);
        wait_ready(200, n);
        chk("tmo_reset_cycles", rst_cnt - r0, 1);

        // reset while a div is in WAIT_DONE
        send(OP_DIV, EIGHT, TWO);
        n = 0;
        while (fpu_idle && n < 20) begin step(); n++; end
        chk("midrst_busy_seen", fpu_idle, 0);
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_strobes", strb(), 0);
        chk("midrst_fpu_reset", fpu_reset, 1);
        chk("midrst_cmd_ready", cmd_ready, 0);
        step();
        rst_n = 1'b1;
        wait_ready(200, n);
        chk("midrst_init_cycles", n, 4);
        chk("midrst_no_stale", stale, 0);
        chk("midrst_flags", rsp_flags, 0);

        // healthy again after recovery
        send(OP_ADD, FOUR, FOUR);
        wait_rsp(100, n);
        chk("post_add_data", rsp_data, EIGHT);
        handshake(1'b1);
        chk("strobe_shape", strobe_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
